// File: rtl/instr_fetch.sv
// instr_fetch: fetches 1..3-word instructions from program memory and hands them to the decoder.
// Optional FETCH_ILLEGAL_TRAP_EN: flag unencodable opcodes and stall until a redirect arrives.
module instr_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  input  logic        pc_load,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] ir_out,
  output logic [15:0] ext1,
  output logic [15:0] ext2,
  output logic [1:0]  ir_len,
  output logic        ir_valid,
  input  logic        ir_ready
`ifdef FETCH_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

`ifdef FETCH_ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, OP, EXT1, EXT2, HOLD} state_t;

  state_t      state;
  logic [15:0] fptr;
  logic        trap;
  logic [1:0]  op_len;
  logic        op_bad;

  // R2/R3 constant generators and register/indirect modes need no extension word
  function automatic logic src_ext(input logic [1:0] as_mode, input logic [3:0] reg_num);
    return ((as_mode == 2'b01) && (reg_num != 4'd3)) ||
           ((as_mode == 2'b11) && (reg_num == 4'd0));
  endfunction

  always_comb begin
    op_len = 2'd1;
    op_bad = 1'b0;
    if (mem_rdata[15:14] != 2'b00) begin
      op_len = 2'd1 + {1'b0, src_ext(mem_rdata[5:4], mem_rdata[11:8])} + {1'b0, mem_rdata[7]};
    end else if (mem_rdata[15:12] == 4'h1) begin
      if (mem_rdata[9:7] == 3'b111) begin
        op_bad = 1'b1;
      end else begin
        op_len = 2'd1 + {1'b0, src_ext(mem_rdata[5:4], mem_rdata[3:0])};
      end
    end else if (mem_rdata[15:12] == 4'h0) begin
      op_bad = 1'b1;
    end
  end

  assign mem_addr = fptr;

`ifdef FETCH_ILLEGAL_TRAP_EN
  assign illegal = trap;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      fptr     <= 16'h0000;
      mem_rd   <= 1'b0;
      ir_valid <= 1'b0;
      ir_out   <= 16'h0000;
      ext1     <= 16'h0000;
      ext2     <= 16'h0000;
      ir_len   <= 2'd1;
      trap     <= 1'b0;
    end else if (state == IDLE) begin
      fptr   <= pc_in & 16'hFFFE;
      mem_rd <= 1'b1;
      state  <= OP;
    end else if (pc_load) begin
      // a redirect wins over any ack or handshake in the same cycle
      fptr     <= pc_in & 16'hFFFE;
      mem_rd   <= 1'b1;
      ir_valid <= 1'b0;
      trap     <= 1'b0;
      state    <= OP;
    end else begin
      case (state)
        OP: if (mem_ack) begin
          ir_out <= mem_rdata;
          ext1   <= 16'h0000;
          ext2   <= 16'h0000;
          fptr   <= fptr + 16'd2;
          ir_len <= op_len;
          trap   <= TRAP_EN && op_bad;
          if (op_len == 2'd1) begin
            mem_rd   <= 1'b0;
            ir_valid <= 1'b1;
            state    <= HOLD;
          end else begin
            state <= EXT1;
          end
        end
        EXT1: if (mem_ack) begin
          ext1 <= mem_rdata;
          fptr <= fptr + 16'd2;
          if (ir_len == 2'd2) begin
            mem_rd   <= 1'b0;
            ir_valid <= 1'b1;
            state    <= HOLD;
          end else begin
            state <= EXT2;
          end
        end
        EXT2: if (mem_ack) begin
          ext2     <= mem_rdata;
          fptr     <= fptr + 16'd2;
          mem_rd   <= 1'b0;
          ir_valid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: if (ir_valid && ir_ready) begin
          // a trapped opcode parks here with ir_valid low until redirected
          ir_valid <= 1'b0;
          if (!trap) begin
            mem_rd <= 1'b1;
            state  <= OP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed testbench for instr_fetch with a zero-wait program memory model.
// Build with FETCH_ILLEGAL_TRAP_EN defined to exercise the illegal-opcode trap.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc_in;
  logic        pc_load;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] ir_out;
  logic [15:0] ext1;
  logic [15:0] ext2;
  logic [1:0]  ir_len;
  logic        ir_valid;
  logic        ir_ready;
`ifdef FETCH_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  int errors = 0;
  int checks = 0;
  bit force_ack = 1'b0;
  logic [15:0] mem_model [logic [15:0]];

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_load(pc_load),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ir_out(ir_out), .ext1(ext1), .ext2(ext2), .ir_len(ir_len),
    .ir_valid(ir_valid), .ir_ready(ir_ready)
`ifdef FETCH_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return 16'h4303;
  endfunction

  // memory acks every request in the same cycle; force_ack injects stray acks
  task automatic mem_update();
    mem_ack   = force_ack | mem_rd;
    mem_rdata = force_ack ? 16'hFFFF : mem_word(mem_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mem_update();
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!ok) begin
        tick();
        if (ir_valid === 1'b1) ok = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd: got %0b expected 0", mem_rd); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ir_valid: got %0b expected 0", ir_valid); end
    checks++; if ({ir_out, ext1, ext2} !== 48'h0) begin errors++; $display("[TB] FAIL reset_words: got %h %h %h expected zeros", ir_out, ext1, ext2); end
    checks++; if (ir_len !== 2'd1) begin errors++; $display("[TB] FAIL reset_ir_len: got %0d expected 1", ir_len); end
`ifdef FETCH_ILLEGAL_TRAP_EN
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %0b expected 0", illegal); end
`endif
    rst_n = 1'b1;
    tick();
    checks++; if ({mem_rd, mem_addr, ir_valid} !== {1'b1, 16'hC000, 1'b0}) begin
      errors++; $display("[TB] FAIL idle_to_op: got rd=%0b addr=%h valid=%0b expected rd=1 addr=c000 valid=0", mem_rd, mem_addr, ir_valid);
    end
  endtask

  task automatic test_single_word();
    tick();
    checks++; if ({ir_valid, ir_out, ir_len, ext1, ext2} !== {1'b1, 16'h4405, 2'd1, 16'h0, 16'h0}) begin
      errors++; $display("[TB] FAIL single_bundle: got v=%0b ir=%h len=%0d e1=%h e2=%h expected v=1 ir=4405 len=1 e1=0 e2=0", ir_valid, ir_out, ir_len, ext1, ext2);
    end
    checks++; if ({mem_rd, mem_addr} !== {1'b0, 16'hC002}) begin
      errors++; $display("[TB] FAIL single_next_addr: got rd=%0b addr=%h expected rd=0 addr=c002", mem_rd, mem_addr);
    end
  endtask

  task automatic test_ready_stall();
    force_ack = 1'b1;
    mem_update();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ({mem_rd, ir_valid, ir_out, ir_len, mem_addr} !== {1'b0, 1'b1, 16'h4405, 2'd1, 16'hC002}) begin
        errors++; $display("[TB] FAIL stall_cycle%0d: got rd=%0b v=%0b ir=%h len=%0d addr=%h expected rd=0 v=1 ir=4405 len=1 addr=c002", i, mem_rd, ir_valid, ir_out, ir_len, mem_addr);
      end
    end
    force_ack = 1'b0;
    ir_ready = 1'b1;
    mem_update();
    tick();
    ir_ready = 1'b0;
    checks++; if ({ir_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'hC002}) begin
      errors++; $display("[TB] FAIL stall_release: got v=%0b rd=%0b addr=%h expected v=0 rd=1 addr=c002", ir_valid, mem_rd, mem_addr);
    end
  endtask

  task automatic test_ext_words();
    bit ok;
    wait_valid(6, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ext_timeout: got no ir_valid expected bundle"); end
    checks++; if ({ir_out, ext1, ext2, ir_len, mem_addr} !== {16'h4035, 16'h1234, 16'h0000, 2'd2, 16'hC006}) begin
      errors++; $display("[TB] FAIL imm_bundle: got ir=%h e1=%h e2=%h len=%0d addr=%h expected 4035 1234 0000 2 c006", ir_out, ext1, ext2, ir_len, mem_addr);
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    wait_valid(6, ok);
    checks++; if ({ok, ir_out, ir_len, ext1} !== {1'b1, 16'h4315, 2'd1, 16'h0000}) begin
      errors++; $display("[TB] FAIL cg_bundle: got ok=%0b ir=%h len=%0d e1=%h expected ok=1 ir=4315 len=1 e1=0000", ok, ir_out, ir_len, ext1);
    end
  endtask

  task automatic test_back_to_back();
    logic [49:0] bundles [4];
    int vt [4];
    int n = 0;
    logic [16:0] t4_state = 17'h0;
    ir_ready = 1'b1;
    tick();
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 4) t4_state = {mem_rd, mem_addr};
      if (ir_valid === 1'b1 && n < 4) begin
        bundles[n] = {ir_out, ext1, ext2, ir_len};
        vt[n] = t;
        n++;
      end
    end
    ir_ready = 1'b0;
    checks++; if (n != 2) begin errors++; $display("[TB] FAIL b2b_count: got %0d bundles expected 2", n); end
    if (n >= 2) begin
      checks++; if (vt[0] != 3 || vt[1] != 7) begin errors++; $display("[TB] FAIL b2b_timing: got cycles %0d,%0d expected 3,7", vt[0], vt[1]); end
      checks++; if (bundles[0] !== {16'h4495, 16'h0002, 16'h0004, 2'd3}) begin errors++; $display("[TB] FAIL b2b_first: got %h expected 4495/0002/0004 len3", bundles[0]); end
      checks++; if (bundles[1] !== {16'h4495, 16'h0006, 16'h0008, 2'd3}) begin errors++; $display("[TB] FAIL b2b_second: got %h expected 4495/0006/0008 len3", bundles[1]); end
    end
    checks++; if (t4_state !== {1'b1, 16'hC00E}) begin
      errors++; $display("[TB] FAIL b2b_no_bubble: got rd/addr %h expected 1/c00e", t4_state);
    end
  endtask

  task automatic test_redirect();
    tick();
    checks++; if ({mem_rd, mem_addr, ir_valid} !== {1'b1, 16'hC016, 1'b0}) begin
      errors++; $display("[TB] FAIL redirect_pre_ext1: got rd=%0b addr=%h v=%0b expected rd=1 addr=c016 v=0", mem_rd, mem_addr, ir_valid);
    end
    pc_in = 16'hD001;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    checks++; if ({mem_rd, mem_addr, ir_valid} !== {1'b1, 16'hD000, 1'b0}) begin
      errors++; $display("[TB] FAIL redirect_addr: got rd=%0b addr=%h v=%0b expected rd=1 addr=d000 v=0", mem_rd, mem_addr, ir_valid);
    end
    tick();
    checks++; if ({ir_valid, ir_out, ir_len, ext1} !== {1'b1, 16'h4A0B, 2'd1, 16'h0000}) begin
      errors++; $display("[TB] FAIL redirect_bundle: got v=%0b ir=%h len=%0d e1=%h expected v=1 ir=4a0b len=1 e1=0000", ir_valid, ir_out, ir_len, ext1);
    end
  endtask

  task automatic test_load_with_ready();
    pc_in = 16'hFFFF;
    pc_load = 1'b1;
    ir_ready = 1'b1;
    tick();
    pc_load = 1'b0;
    ir_ready = 1'b0;
    checks++; if ({ir_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'hFFFE}) begin
      errors++; $display("[TB] FAIL load_ready: got v=%0b rd=%0b addr=%h expected v=0 rd=1 addr=fffe", ir_valid, mem_rd, mem_addr);
    end
    tick();
    checks++; if ({ir_valid, ir_out, mem_addr} !== {1'b1, 16'h4C0D, 16'h0000}) begin
      errors++; $display("[TB] FAIL addr_wrap: got v=%0b ir=%h addr=%h expected v=1 ir=4c0d addr=0000", ir_valid, ir_out, mem_addr);
    end
  endtask

  task automatic test_illegal();
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    tick();
    checks++; if ({ir_valid, ir_out, ir_len} !== {1'b1, 16'h0000, 2'd1}) begin
      errors++; $display("[TB] FAIL zero_word_bundle: got v=%0b ir=%h len=%0d expected v=1 ir=0000 len=1", ir_valid, ir_out, ir_len);
    end
`ifdef FETCH_ILLEGAL_TRAP_EN
    checks++; if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL illegal_flag: got %0b expected 1", illegal); end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({ir_valid, mem_rd, illegal} !== {1'b0, 1'b0, 1'b1}) begin
        errors++; $display("[TB] FAIL trap_stall%0d: got v=%0b rd=%0b ill=%0b expected v=0 rd=0 ill=1", i, ir_valid, mem_rd, illegal);
      end
    end
    pc_in = 16'h0004;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    checks++; if ({mem_rd, mem_addr, illegal} !== {1'b1, 16'h0004, 1'b0}) begin
      errors++; $display("[TB] FAIL trap_exit: got rd=%0b addr=%h ill=%0b expected rd=1 addr=0004 ill=0", mem_rd, mem_addr, illegal);
    end
    tick();
    checks++; if ({ir_valid, ir_out, ir_len, illegal} !== {1'b1, 16'h1395, 2'd1, 1'b1}) begin
      errors++; $display("[TB] FAIL fmt2_illegal: got v=%0b ir=%h len=%0d ill=%0b expected v=1 ir=1395 len=1 ill=1", ir_valid, ir_out, ir_len, illegal);
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    checks++; if ({ir_valid, mem_rd} !== {1'b0, 1'b0}) begin
      errors++; $display("[TB] FAIL fmt2_stall: got v=%0b rd=%0b expected v=0 rd=0", ir_valid, mem_rd);
    end
`else
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    checks++; if ({ir_valid, mem_rd, mem_addr} !== {1'b0, 1'b1, 16'h0002}) begin
      errors++; $display("[TB] FAIL zero_word_continue: got v=%0b rd=%0b addr=%h expected v=0 rd=1 addr=0002", ir_valid, mem_rd, mem_addr);
    end
    tick();
    checks++; if ({ir_valid, ir_out} !== {1'b1, 16'h4B0C}) begin
      errors++; $display("[TB] FAIL after_zero_word: got v=%0b ir=%h expected v=1 ir=4b0c", ir_valid, ir_out);
    end
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    tick();
    checks++; if ({ir_valid, ir_out, ir_len, mem_addr} !== {1'b1, 16'h1395, 2'd1, 16'h0006}) begin
      errors++; $display("[TB] FAIL fmt2_passthru: got v=%0b ir=%h len=%0d addr=%h expected v=1 ir=1395 len=1 addr=0006", ir_valid, ir_out, ir_len, mem_addr);
    end
`endif
  endtask

  task automatic test_reset_midfetch();
    int first_valid = 0;
    pc_in = 16'hC008;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_rd, ir_valid, mem_addr} !== {1'b0, 1'b0, 16'h0000}) begin
      errors++; $display("[TB] FAIL async_reset: got rd=%0b v=%0b addr=%h expected rd=0 v=0 addr=0000", mem_rd, ir_valid, mem_addr);
    end
    tick();
    rst_n = 1'b1;
    mem_update();
    tick();
    checks++; if ({ir_valid, mem_addr} !== {1'b0, 16'hC008}) begin
      errors++; $display("[TB] FAIL refetch_start: got v=%0b addr=%h expected v=0 addr=c008", ir_valid, mem_addr);
    end
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (ir_valid === 1'b1 && first_valid == 0) first_valid = t;
    end
    checks++; if (first_valid != 3) begin errors++; $display("[TB] FAIL refetch_timing: got valid at cycle %0d expected 3", first_valid); end
    checks++; if ({ir_out, ext1, ext2, ir_len} !== {16'h4495, 16'h0002, 16'h0004, 2'd3}) begin
      errors++; $display("[TB] FAIL refetch_bundle: got %h %h %h len=%0d expected 4495 0002 0004 3", ir_out, ext1, ext2, ir_len);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pc_in = 16'hC000;
    pc_load = 1'b0;
    ir_ready = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0000;
    mem_model[16'hC000] = 16'h4405;
    mem_model[16'hC002] = 16'h4035;
    mem_model[16'hC004] = 16'h1234;
    mem_model[16'hC006] = 16'h4315;
    mem_model[16'hC008] = 16'h4495;
    mem_model[16'hC00A] = 16'h0002;
    mem_model[16'hC00C] = 16'h0004;
    mem_model[16'hC00E] = 16'h4495;
    mem_model[16'hC010] = 16'h0006;
    mem_model[16'hC012] = 16'h0008;
    mem_model[16'hC014] = 16'h4035;
    mem_model[16'hC016] = 16'h5555;
    mem_model[16'hD000] = 16'h4A0B;
    mem_model[16'hFFFE] = 16'h4C0D;
    mem_model[16'h0000] = 16'h0000;
    mem_model[16'h0002] = 16'h4B0C;
    mem_model[16'h0004] = 16'h1395;
    $display("[TB] instr_fetch directed test start");
    test_reset();
    test_single_word();
    test_ready_stall();
    test_ext_words();
    test_back_to_back();
    test_redirect();
    test_load_with_ready();
    test_illegal();
    test_reset_midfetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
